// File: rtl/byte_serial_adder_seq.sv
// byte_serial_adder_seq
//   Wide adder built from an external 8-bit ripple-carry stage. Operands are
//   latched on accept and streamed through the stage one byte per clock,
//   least-significant byte first, with the carry registered between bytes.
//   The result is then held on a valid/ready output until it is taken.
//
//   Optional feature: define SEQ_SUB_EN to enable subtraction (op_sub).
//   In that build a latched op_sub inverts the B bytes and forces the byte-0
//   carry-in to 1, so out_cout = 1 means "no borrow". Without the macro,
//   op_sub is ignored and only addition is performed.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (ready only in IDLE, low during rst)
//   in_a, in_b, in_cin  operands and carry into byte 0
//   op_sub              subtract request (SEQ_SUB_EN builds only)
//   out_valid/out_ready result handshake
//   out_sum, out_cout   result and carry out of the top byte (0 unless valid)
//   add_a/add_b/add_cin byte operands driven to the 8-bit adder (0 outside RUN)
//   add_sum/add_cout    combinational result of the 8-bit adder
module byte_serial_adder_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_a,
    input  logic [8*NBYTES-1:0] in_b,
    input  logic                in_cin,
    input  logic                op_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_sum,
    output logic                out_cout,
    output logic [7:0]          add_a,
    output logic [7:0]          add_b,
    output logic                add_cin,
    input  logic [7:0]          add_sum,
    input  logic                add_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Latched request; the subtract flag only exists when the feature does.
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
`ifdef SEQ_SUB_EN
        logic         sub;
`endif
    } req_t;

    state_t          state, state_nxt;
    req_t            req;
    logic [W-1:0]    sum_reg;
    logic            carry_reg;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            last;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic            cin0;

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST);

    // Current byte slices; idx never exceeds LAST so the select stays in range.
    assign a_byte = req.a[8*idx +: 8];

`ifdef SEQ_SUB_EN
    assign b_byte = req.sub ? ~req.b[8*idx +: 8] : req.b[8*idx +: 8];
    assign cin0   = req.sub ? 1'b1 : req.cin;
`else
    assign b_byte = req.b[8*idx +: 8];
    assign cin0   = req.cin;
    // op_sub has no function in this build; sink it so it is visibly unused.
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        add_a     = 8'd0;
        add_b     = 8'd0;
        add_cin   = 1'b0;

        case (state)
            IDLE: begin
                // Ready is masked by rst so nothing is accepted into a reset.
                in_ready = !rst;
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                add_a   = a_byte;
                add_b   = b_byte;
                add_cin = (idx == '0) ? cin0 : carry_reg;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = sum_reg;
                out_cout  = carry_reg;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request capture and per-byte accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req       <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req.a   <= in_a;
                        req.b   <= in_b;
                        req.cin <= in_cin;
`ifdef SEQ_SUB_EN
                        req.sub <= op_sub;
`endif
                        idx     <= '0;
                    end
                end
                RUN: begin
                    sum_reg[8*idx +: 8] <= add_sum;
                    carry_reg           <= add_cout;
                    // On the last byte idx is left alone; it is cleared on
                    // the next accept.
                    if (!last) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
